// File: rtl/two_fsk_demod_if.sv
// Signal bundle between an FSK waveform source/consumer and the 2-FSK demodulator.
// The demodulator takes the slave side: it samples y_in and drives the decisions.
interface two_fsk_demod_if;
  logic       y_in;
  logic       tone_valid;
  logic       tone_bit;
  logic       bit_valid;
  logic       bit_out;
  logic       carrier;
  logic [7:0] err_cnt;

  modport master (
    output y_in,
    input  tone_valid, tone_bit, bit_valid,
    input  bit_out, carrier, err_cnt
  );

  modport slave (
    input  y_in,
    output tone_valid, tone_bit, bit_valid,
    output bit_out, carrier, err_cnt
  );
endinterface

// File: rtl/two_fsk_demod.sv
// Non-coherent 2-FSK demodulator: classifies carrier periods by edge spacing,
// then integrates per-tone time over fixed symbol windows to decide each bit.
module two_fsk_demod #(
  parameter int unsigned T1_MIN  = 7,
  parameter int unsigned T1_MAX  = 9,
  parameter int unsigned T0_MIN  = 3,
  parameter int unsigned T0_MAX  = 5,
  parameter int unsigned PER_MAX = 15,
  parameter int unsigned SYM_LEN = 32,
  parameter int unsigned ACC_W   = 7
) (
  input logic           clk,
  input logic           reset,
  two_fsk_demod_if.slave bus
);

  localparam int unsigned SYM_W = $clog2(SYM_LEN);
  localparam logic [3:0] P_MAX = 4'(PER_MAX);
  localparam logic [3:0] T1_LO = 4'(T1_MIN);
  localparam logic [3:0] T1_HI = 4'(T1_MAX);
  localparam logic [3:0] T0_LO = 4'(T0_MIN);
  localparam logic [3:0] T0_HI = 4'(T0_MAX);
  localparam logic [SYM_W-1:0] SYM_END = SYM_W'(SYM_LEN - 1);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t state, state_nx;

  logic             y_s, y_d, rise;
  logic [3:0]       per_cnt, tone_per;
  logic             tone_v, tone_b;
  logic [7:0]       errs;
  logic             first, is_t1, is_t0;
  logic [SYM_W-1:0] sym_cnt, sym_nx;
  logic [ACC_W-1:0] acc1, acc0, acc1_nx, acc0_nx;
  logic [ACC_W-1:0] per_ext;
  logic             bit_v, bit_v_nx;
  logic             bit_o, bit_o_nx;
  logic             car, car_nx;

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [3:0]       b
  );
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W-3){1'b0}}, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  assign rise    = y_s & ~y_d;
  assign first   = (per_cnt == P_MAX);
  assign is_t1   = (per_cnt >= T1_LO) && (per_cnt <= T1_HI);
  assign is_t0   = (per_cnt >= T0_LO) && (per_cnt <= T0_HI);
  assign per_ext = ACC_W'(tone_per);

  // Edge detector, period counter and per-period classifier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_s      <= 1'b0;
      y_d      <= 1'b0;
      per_cnt  <= P_MAX;
      tone_per <= '0;
      tone_v   <= 1'b0;
      tone_b   <= 1'b0;
      errs     <= '0;
    end else begin
      y_s    <= bus.y_in;
      y_d    <= y_s;
      tone_v <= 1'b0;
      if (rise) begin
        per_cnt <= 4'd1;
        unique case (1'b1)
          first: ;
          is_t1: begin
            tone_v   <= 1'b1;
            tone_b   <= 1'b1;
            tone_per <= per_cnt;
          end
          is_t0: begin
            tone_v   <= 1'b1;
            tone_b   <= 1'b0;
            tone_per <= per_cnt;
          end
          default: begin
            if (errs != 8'hff) errs <= errs + 8'd1;
          end
        endcase
      end else if (per_cnt != P_MAX) begin
        per_cnt <= per_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sym_cnt <= '0;
      acc1    <= '0;
      acc0    <= '0;
      bit_v   <= 1'b0;
      bit_o   <= 1'b0;
      car     <= 1'b0;
    end else begin
      state   <= state_nx;
      sym_cnt <= sym_nx;
      acc1    <= acc1_nx;
      acc0    <= acc0_nx;
      bit_v   <= bit_v_nx;
      bit_o   <= bit_o_nx;
      car     <= car_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sym_nx   = sym_cnt;
    acc1_nx  = acc1;
    acc0_nx  = acc0;
    bit_v_nx = 1'b0;
    bit_o_nx = bit_o;
    car_nx   = car;
    unique case (state)
      IDLE: begin
        if (tone_v) begin
          state_nx = TRACK;
          car_nx   = 1'b1;
          sym_nx   = SYM_W'(1);
          acc1_nx  = tone_b ? per_ext : '0;
          acc0_nx  = tone_b ? '0 : per_ext;
        end
      end
      TRACK: begin
        if (first) begin
          state_nx = IDLE;
          car_nx   = 1'b0;
          sym_nx   = '0;
          acc1_nx  = '0;
          acc0_nx  = '0;
        end else if (sym_cnt == SYM_END) begin
          // A tone landing on the boundary opens the next window
          bit_v_nx = 1'b1;
          bit_o_nx = (acc1 > acc0);
          sym_nx   = '0;
          acc1_nx  = (tone_v && tone_b) ? per_ext : '0;
          acc0_nx  = (tone_v && !tone_b) ? per_ext : '0;
        end else begin
          sym_nx = sym_cnt + 1'b1;
          if (tone_v && tone_b) acc1_nx = sat_add(acc1, tone_per);
          if (tone_v && !tone_b) acc0_nx = sat_add(acc0, tone_per);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.tone_valid = tone_v;
  assign bus.tone_bit   = tone_b;
  assign bus.bit_valid  = bit_v;
  assign bus.bit_out    = bit_o;
  assign bus.carrier    = car;
  assign bus.err_cnt    = errs;

endmodule

// File: tb/tb_two_fsk_demod.sv
// Directed bench for two_fsk_demod: tone streams, switching, glitch,
// silence and mid-symbol reset, with hand-derived event timings.
module tb_two_fsk_demod;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  int cyc, tv_n, tv_first, car_first, car_fall;
  int bv_n, bv_first, bv_last, bv_ones, gap_bad;
  int bv_val [8];

  two_fsk_demod_if bus ();

  two_fsk_demod dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_logs();
    cyc = 0;
    tv_n = 0;
    tv_first = -1;
    car_first = -1;
    car_fall = -1;
    bv_n = 0;
    bv_first = -1;
    bv_last = -1;
    bv_ones = 0;
    gap_bad = 0;
    for (int i = 0; i < 8; i++) bv_val[i] = -1;
  endtask

  task automatic step(input logic v);
    bus.y_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tone_valid) begin
      tv_n++;
      if (tv_first < 0) tv_first = cyc;
    end
    if (bus.carrier && car_first < 0) car_first = cyc;
    if (!bus.carrier && car_first >= 0 && car_fall < 0)
      car_fall = cyc;
    if (bus.bit_valid) begin
      if (bv_n > 0 && cyc - bv_last != 32) gap_bad++;
      if (bv_n == 0) bv_first = cyc;
      if (bv_n < 8) bv_val[bv_n] = int'(bus.bit_out);
      bv_last = cyc;
      bv_ones += int'(bus.bit_out);
      bv_n++;
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic do_reset();
    bus.y_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    bus.y_in = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.tone_valid !== 1'b0) begin
      errs++; $display("FAIL rst_tone_valid got=%b want=0", bus.tone_valid);
    end
    checks++;
    if (bus.tone_bit !== 1'b0) begin
      errs++; $display("FAIL rst_tone_bit got=%b want=0", bus.tone_bit);
    end
    checks++;
    if (bus.bit_valid !== 1'b0) begin
      errs++; $display("FAIL rst_bit_valid got=%b want=0", bus.bit_valid);
    end
    checks++;
    if (bus.bit_out !== 1'b0) begin
      errs++; $display("FAIL rst_bit_out got=%b want=0", bus.bit_out);
    end
    checks++;
    if (bus.carrier !== 1'b0) begin
      errs++; $display("FAIL rst_carrier got=%b want=0", bus.carrier);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errs++; $display("FAIL rst_err_cnt got=%0d want=0", bus.err_cnt);
    end
  endtask

  task automatic test_tone1();
    do_reset();
    wave(4, 4, 20);
    checks++;
    if (tv_first != 10) begin
      errs++; $display("FAIL t1_tv_first got=%0d want=10", tv_first);
    end
    checks++;
    if (car_first != 11) begin
      errs++; $display("FAIL t1_car_first got=%0d want=11", car_first);
    end
    checks++;
    if (tv_n != 19) begin
      errs++; $display("FAIL t1_tv_n got=%0d want=19", tv_n);
    end
    checks++;
    if (bus.tone_bit !== 1'b1) begin
      errs++; $display("FAIL t1_tone_bit got=%b want=1", bus.tone_bit);
    end
    checks++;
    if (bv_first != 42) begin
      errs++; $display("FAIL t1_bv_first got=%0d want=42", bv_first);
    end
    checks++;
    if (bv_n != 4 || bv_ones != 4) begin
      errs++;
      $display("FAIL t1_bits got=%0d/%0d want=4/4", bv_ones, bv_n);
    end
    checks++;
    if (gap_bad != 0) begin
      errs++; $display("FAIL t1_bv_gap got=%0d want=0", gap_bad);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errs++; $display("FAIL t1_err_cnt got=%0d want=0", bus.err_cnt);
    end
  endtask

  task automatic test_tone0();
    do_reset();
    wave(2, 2, 40);
    checks++;
    if (tv_first != 6) begin
      errs++; $display("FAIL t0_tv_first got=%0d want=6", tv_first);
    end
    checks++;
    if (tv_n != 39) begin
      errs++; $display("FAIL t0_tv_n got=%0d want=39", tv_n);
    end
    checks++;
    if (car_first != 7) begin
      errs++; $display("FAIL t0_car_first got=%0d want=7", car_first);
    end
    checks++;
    if (bus.tone_bit !== 1'b0) begin
      errs++; $display("FAIL t0_tone_bit got=%b want=0", bus.tone_bit);
    end
    checks++;
    if (bv_first != 38) begin
      errs++; $display("FAIL t0_bv_first got=%0d want=38", bv_first);
    end
    checks++;
    if (bv_n != 4 || bv_ones != 0) begin
      errs++;
      $display("FAIL t0_bits got=%0d/%0d want=0/4", bv_ones, bv_n);
    end
    checks++;
    if (gap_bad != 0) begin
      errs++; $display("FAIL t0_bv_gap got=%0d want=0", gap_bad);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errs++; $display("FAIL t0_err_cnt got=%0d want=0", bus.err_cnt);
    end
  endtask

  task automatic test_switch();
    do_reset();
    wave(4, 4, 7);
    wave(2, 2, 15);
    checks++;
    if (bv_n != 3) begin
      errs++; $display("FAIL sw_bv_n got=%0d want=3", bv_n);
    end
    checks++;
    if (bv_val[0] != 1) begin
      errs++; $display("FAIL sw_bit0 got=%0d want=1", bv_val[0]);
    end
    checks++;
    if (bv_val[1] != 1) begin
      errs++; $display("FAIL sw_bit1 got=%0d want=1", bv_val[1]);
    end
    checks++;
    if (bv_val[2] != 0) begin
      errs++; $display("FAIL sw_bit2 got=%0d want=0", bv_val[2]);
    end
    checks++;
    if (car_fall >= 0 || bus.err_cnt !== 8'd0) begin
      errs++;
      $display("FAIL sw_link got=%0d,%0d want=-1,0",
               car_fall, bus.err_cnt);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    wave(4, 4, 6);
    wave(1, 1, 1);
    wave(4, 4, 12);
    checks++;
    if (bus.err_cnt !== 8'd1) begin
      errs++; $display("FAIL gl_err_cnt got=%0d want=1", bus.err_cnt);
    end
    checks++;
    if (car_fall >= 0 || bus.carrier !== 1'b1) begin
      errs++;
      $display("FAIL gl_carrier got=%0d,%b want=-1,1",
               car_fall, bus.carrier);
    end
    checks++;
    if (bv_n != 4 || bv_ones != 4) begin
      errs++;
      $display("FAIL gl_bits got=%0d/%0d want=4/4", bv_ones, bv_n);
    end
    checks++;
    if (gap_bad != 0) begin
      errs++; $display("FAIL gl_bv_gap got=%0d want=0", gap_bad);
    end
  endtask

  task automatic test_silence();
    do_reset();
    wave(4, 4, 8);
    wave(0, 30, 1);
    checks++;
    if (car_fall != 73) begin
      errs++; $display("FAIL si_car_fall got=%0d want=73", car_fall);
    end
    checks++;
    if (bv_n != 1) begin
      errs++; $display("FAIL si_bv_n got=%0d want=1", bv_n);
    end
    checks++;
    if (bus.bit_out !== 1'b1) begin
      errs++; $display("FAIL si_bit_hold got=%b want=1", bus.bit_out);
    end
    clear_logs();
    wave(4, 4, 8);
    checks++;
    if (tv_first != 10) begin
      errs++; $display("FAIL si_re_tv got=%0d want=10", tv_first);
    end
    checks++;
    if (car_first != 11) begin
      errs++; $display("FAIL si_re_car got=%0d want=11", car_first);
    end
    checks++;
    if (bv_first != 42) begin
      errs++; $display("FAIL si_re_bv got=%0d want=42", bv_first);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errs++; $display("FAIL si_err_cnt got=%0d want=0", bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wave(4, 4, 6);
    wave(4, 0, 1);
    checks++;
    if (bus.carrier !== 1'b1 || bus.bit_out !== 1'b1) begin
      errs++;
      $display("FAIL rm_pre got=%b%b want=11", bus.carrier, bus.bit_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.carrier !== 1'b0 || bus.bit_out !== 1'b0) begin
      errs++;
      $display("FAIL rm_async got=%b%b want=00", bus.carrier, bus.bit_out);
    end
    checks++;
    if (bus.tone_bit !== 1'b0 || bus.bit_valid !== 1'b0) begin
      errs++;
      $display("FAIL rm_async2 got=%b%b want=00",
               bus.tone_bit, bus.bit_valid);
    end
    bus.y_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    wave(4, 4, 8);
    checks++;
    if (tv_first != 10) begin
      errs++; $display("FAIL rm_tv_first got=%0d want=10", tv_first);
    end
    checks++;
    if (bv_first != 42) begin
      errs++; $display("FAIL rm_bv_first got=%0d want=42", bv_first);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin
      errs++; $display("FAIL rm_err_cnt got=%0d want=0", bus.err_cnt);
    end
  endtask

  initial begin
    bus.y_in = 1'b0;
    clear_logs();
    test_reset();
    test_tone1();
    test_tone0();
    test_switch();
    test_glitch();
    test_silence();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/two_fsk_demod.md
Name: two_fsk_demod

Overview:
Non-coherent 2-FSK demodulator; receive-side counterpart of the team's 2-FSK modulator. Takes the modulator's 1-bit square-wave output and measures the rising-edge-to-rising-edge period to classify each carrier cycle:
- Long period (clk/8 tone) = bit 1.
- Short period (clk/4 tone) = bit 0.

It then forms symbol decisions over a fixed symbol window and tracks carrier presence.

Parameters:
T1_MIN, 7, minimum period in clocks classified as tone 1
T1_MAX, 9, maximum period classified as tone 1
T0_MIN, 3, minimum period classified as tone 0
T0_MAX, 5, maximum period classified as tone 0
PER_MAX, 15, period counter saturation value; reaching it means carrier lost
SYM_LEN, 32, clocks per symbol decision window
ACC_W, 7, width of per-tone clock accumulators; saturating

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
y_in  in  1  FSK waveform, synchronous to clk
tone_valid  out  1  one-cycle pulse per classified carrier period
tone_bit  out  1  class of the last period: 1 = tone 1, 0 = tone 0
bit_valid  out  1  one-cycle pulse per symbol decision
bit_out  out  1  demodulated symbol; held between decisions
carrier  out  1  1 while in TRACK state
err_cnt  out  8  count of out-of-range periods; saturates at 255

Behaviour:
- Reset: clk is the single clock; reset is asynchronous, active-low.
  - While reset=0: all outputs 0, internal regs 0, per_cnt = PER_MAX, state = IDLE.
- Input pipeline:
  - y_s <= y_in; y_d <= y_s; rise = y_s & ~y_d (combinational).
- Period counter per_cnt (4 bits):
  - On rise: per_cnt <= 1.
  - Otherwise: increment unless already at PER_MAX.
  - Measured period = per_cnt value in the rise cycle. An 8-clock input period measures 8.
- Classification, registered in the rise cycle:
  - Rise with per_cnt == PER_MAX: first edge after silence or reset. Restart the counter only; no tone_valid, no error.
  - Period in [T1_MIN, T1_MAX]: tone_valid=1, tone_bit=1.
  - Period in [T0_MIN, T0_MAX]: tone_valid=1, tone_bit=0.
  - Any other period: no tone_valid; err_cnt +1, saturating at 255.
  - tone_valid appears 2 clock edges after y_in is first sampled high at the period's ending rise.
- FSM states: IDLE, TRACK.
  - IDLE, cycle with tone_valid=1: go to TRACK; carrier <= 1; sym_cnt <= 1; load that tone's accumulator with its period, the other with 0.
  - TRACK, each cycle:
    - sym_cnt increments.
    - Each tone_valid adds its measured period to acc1 (tone 1) or acc0 (tone 0). Accumulators saturate at 2^ACC_W-1.
  - TRACK, cycle with sym_cnt == SYM_LEN-1:
    - Next cycle bit_valid=1, bit_out = (acc1 > acc0); tie gives 0.
    - sym_cnt <= 0; accumulators cleared.
    - A tone_valid coinciding with this boundary cycle is loaded into the new symbol's accumulator, not the closing one.
  - TRACK, per_cnt reaching PER_MAX: go to IDLE; carrier <= 0; accumulators and sym_cnt cleared; partial symbol discarded with no bit_valid. bit_out holds its last value.
  - Carrier loss has priority over a boundary decision in the same cycle.
- Symbol timing:
  - First bit_valid occurs exactly SYM_LEN clocks after the tone_valid that caused acquisition.
  - Subsequent bit_valid every SYM_LEN clocks.
- Out-of-range periods in TRACK do not drop carrier; only per_cnt saturation does.
- Asserting reset mid-symbol clears everything immediately. After release, the first rise is a first-edge event.

Test Plan:
- Continuous clk/8 square wave (4 high/4 low):
  - First tone_valid at the 2nd rise.
  - carrier=1 the cycle after.
  - bit_valid every 32 clocks, each with bit_out=1.
  - tone_bit=1; err_cnt stays 0.
- Continuous clk/4 square wave (2 high/2 low):
  - bit_valid every 32 clocks, each with bit_out=0.
  - tone_valid every 4 clocks; err_cnt=0.
- Tone switch in mid-window:
  - Drive clk/8, switch to clk/4 at an edge 24 clocks into a symbol window.
  - That window decides 1 (acc1≈24 > acc0≈8).
  - The following window decides 0.
- Glitch:
  - Insert one period of 2 clocks (1 high/1 low) into a clk/8 stream.
  - err_cnt increments by 1.
  - carrier stays 1; symbol decisions stay 1.
- Silence:
  - Hold y_in=0 after TRACK.
  - carrier drops to 0 when per_cnt reaches 15; no bit_valid for the partial window.
  - Restart of clk/8: no error on the first rise; reacquire at the 2nd rise.
- Reset mid-operation:
  - Pull reset low 10 clocks into a symbol.
  - All outputs 0 immediately (asynchronous).
  - After release with clk/8 input, err_cnt remains 0 and the first bit_valid comes 32 clocks after reacquisition.
